// File: rtl/tmp_seq_pkg.sv
// Shared types and per-phase switch words for the temperature-sensor conversion sequencer.
// The switch words describe which analog switches/sources each phase closes.
package tmp_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_DIODE     = 3'd2,
        ST_BIGDIODE  = 3'd3,
        ST_HCHARGE   = 3'd4,
        ST_LCHARGE   = 3'd5,
        ST_OUTPUT    = 3'd6,
        ST_GAP       = 3'd7
    } state_t;

    typedef struct packed {
        logic pi1;
        logic pi2;
        logic pii1;
        logic pii2;
        logic pa;
        logic pb;
        logic pc;
        logic pd;
        logic src;
        logic snk;
        logic rst;
    } sw_t;

    localparam sw_t SW_QUIET     = '{default: 1'b0};
    localparam sw_t SW_IDLE      = '{rst: 1'b1, default: 1'b0};
    localparam sw_t SW_PRECHARGE = '{pi1: 1'b1, pi2: 1'b1, rst: 1'b1, default: 1'b0};
    localparam sw_t SW_DIODE     = '{pa: 1'b1, pii1: 1'b1, default: 1'b0};
    localparam sw_t SW_BIGDIODE  = '{pb: 1'b1, pii2: 1'b1, default: 1'b0};
    localparam sw_t SW_HCHARGE   = '{pc: 1'b1, src: 1'b1, default: 1'b0};
    localparam sw_t SW_LCHARGE   = '{pd: 1'b1, snk: 1'b1, default: 1'b0};

    // GAP and OUTPUT open every switch; GAP's rst is patched by the caller.
    function automatic sw_t phase_switches(input state_t s);
        sw_t w;
        case (s)
            ST_IDLE:      w = SW_IDLE;
            ST_PRECHARGE: w = SW_PRECHARGE;
            ST_DIODE:     w = SW_DIODE;
            ST_BIGDIODE:  w = SW_BIGDIODE;
            ST_HCHARGE:   w = SW_HCHARGE;
            ST_LCHARGE:   w = SW_LCHARGE;
            ST_OUTPUT:    w = SW_QUIET;
            ST_GAP:       w = SW_QUIET;
            default:      w = SW_IDLE;
        endcase
        return w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/tmp_cmp_sync.sv
// Two-flop synchroniser bringing the free-running comparator output into the clk domain.
module tmp_cmp_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic [1:0] sync_q;

    // Shift register; first stage may go metastable, second stage is the clean copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], async_i};
        end
    end

    assign sync_o = sync_q[1];

endmodule

// File: rtl/tmp_phase_seq.sv
// Conversion sequencer: walks the sensor switch network through its phases, counts the
// two charge phases until the comparator trips, and reports both counts with a valid pulse.
module tmp_phase_seq
    import tmp_seq_pkg::*;
#(
    parameter int CNT_W     = 10,
    parameter int PRE_CYC   = 4,
    parameter int DIODE_CYC = 8,
    parameter int NOV_CYC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp,
    output logic             PI1,
    output logic             PI2,
    output logic             PII1,
    output logic             PII2,
    output logic             PA,
    output logic             PB,
    output logic             PC,
    output logic             PD,
    output logic             src,
    output logic             snk,
    output logic             rst,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] cnt_h,
    output logic [CNT_W-1:0] cnt_l,
    output logic             ovf
);

    localparam int TMR_W = $clog2(max3(PRE_CYC, DIODE_CYC, NOV_CYC) + 1);

    localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] PRE_LAST   = TMR_W'(PRE_CYC - 1);
    localparam logic [TMR_W-1:0] DIODE_LAST = TMR_W'(DIODE_CYC - 1);
    localparam logic [TMR_W-1:0] NOV_LAST   = TMR_W'(NOV_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_MAX - CNT_ONE;

    logic cmp_s;

    state_t           state_q, state_d;
    state_t           ret_q, ret_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cap_h_q, cap_h_d;
    logic [CNT_W-1:0] cap_l_q, cap_l_d;
    logic             ovf_int_q, ovf_int_d;

    sw_t              sw_q, sw_d, phase_sw;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
    logic [CNT_W-1:0] cnt_l_q, cnt_l_d;
    logic             ovf_q, ovf_d;

    tmp_cmp_sync u_cmp_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (cmp),
        .sync_o  (cmp_s)
    );

    // Sequencer state, phase timer, charge counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ret_q     <= ST_IDLE;
            tmr_q     <= TMR_ZERO;
            cnt_q     <= CNT_ZERO;
            cap_h_q   <= CNT_ZERO;
            cap_l_q   <= CNT_ZERO;
            ovf_int_q <= 1'b0;
            sw_q      <= SW_IDLE;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            cnt_h_q   <= CNT_ZERO;
            cnt_l_q   <= CNT_ZERO;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            cap_h_q   <= cap_h_d;
            cap_l_q   <= cap_l_d;
            ovf_int_q <= ovf_int_d;
            sw_q      <= sw_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            cnt_h_q   <= cnt_h_d;
            cnt_l_q   <= cnt_l_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state logic, then output words decoded from the next state so each phase's
    // switches are already closed in its first cycle.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        cap_h_d   = cap_h_q;
        cap_l_d   = cap_l_q;
        ovf_int_d = ovf_int_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRECHARGE;
                    tmr_d     = TMR_ZERO;
                    ovf_int_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRECHARGE: begin
                if (tmr_q == PRE_LAST) begin
                    state_d = ST_GAP;
                    ret_d   = ST_DIODE;
                    tmr_d   = TMR_ZERO;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_DIODE: begin
                if (tmr_q == DIODE_LAST) begin
                    state_d = ST_GAP;
                    ret_d   = ST_BIGDIODE;
                    tmr_d   = TMR_ZERO;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            ST_BIGDIODE: begin
                if (tmr_q == DIODE_LAST) begin
                    state_d = ST_GAP;
                    ret_d   = ST_HCHARGE;
                    tmr_d   = TMR_ZERO;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            // A trip wins over saturation; saturation exits on the cycle the count hits max.
            ST_HCHARGE: begin
                if (cmp_s) begin
                    cap_h_d = cnt_q;
                    state_d = ST_GAP;
                    ret_d   = ST_LCHARGE;
                    tmr_d   = TMR_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = CNT_MAX;
                    cap_h_d   = CNT_MAX;
                    ovf_int_d = 1'b1;
                    state_d   = ST_GAP;
                    ret_d     = ST_LCHARGE;
                    tmr_d     = TMR_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_LCHARGE: begin
                if (!cmp_s) begin
                    cap_l_d = cnt_q;
                    state_d = ST_OUTPUT;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d     = CNT_MAX;
                    cap_l_d   = CNT_MAX;
                    ovf_int_d = 1'b1;
                    state_d   = ST_OUTPUT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_OUTPUT: begin
                state_d = ST_IDLE;
            end
            ST_GAP: begin
                if (tmr_q == NOV_LAST) begin
                    state_d = ret_q;
                    tmr_d   = TMR_ZERO;
                    cnt_d   = CNT_ZERO;
                end else begin
                    tmr_d = tmr_q + TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        phase_sw = phase_switches(state_d);
        sw_d     = phase_sw;
        sw_d.rst = (state_d == ST_GAP) ? sw_q.rst : phase_sw.rst;
        busy_d   = (state_d != ST_IDLE);
        valid_d  = (state_d == ST_OUTPUT);

        if (valid_d) begin
            cnt_h_d = cap_h_d;
            cnt_l_d = cap_l_d;
            ovf_d   = ovf_int_d;
        end else begin
            cnt_h_d = cnt_h_q;
            cnt_l_d = cnt_l_q;
            ovf_d   = ovf_q;
        end
    end

    assign PI1   = sw_q.pi1;
    assign PI2   = sw_q.pi2;
    assign PII1  = sw_q.pii1;
    assign PII2  = sw_q.pii2;
    assign PA    = sw_q.pa;
    assign PB    = sw_q.pb;
    assign PC    = sw_q.pc;
    assign PD    = sw_q.pd;
    assign src   = sw_q.src;
    assign snk   = sw_q.snk;
    assign rst   = sw_q.rst;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign cnt_h = cnt_h_q;
    assign cnt_l = cnt_l_q;
    assign ovf   = ovf_q;

endmodule
